// File: rtl/sdram_test_pkg.sv
// Shared SDRAM memory-test definitions: FSM states, data width and the test
// pattern, so the pattern writer and the read checker can never diverge.
package sdram_test_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned IDX_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Word n of the test image is {~n, n} with n zero-extended to 64 bits.
  function automatic logic [DATA_W-1:0] pattern_word(input logic [IDX_W-1:0] idx);
    return {~idx, idx};
  endfunction

endpackage

// File: rtl/sdram_read_checker_if.sv
// Avalon-MM read-only master bus between the read checker and the SDRAM port.
interface sdram_read_checker_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
);

  logic [ADDR_W-1:0] address;
  logic [7:0]        burstcount;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, burstcount, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sdram_outst_cnt.sv
// In-flight read counter; full_nxt_c flags that the count after this edge
// will have reached MAX_OUTST, so a registered read request can be gated.
module sdram_outst_cnt #(
  parameter int unsigned MAX_OUTST = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full_nxt_c
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    cnt_n = cnt;
    if (clr) begin
      cnt_n = '0;
    end else if (inc && !dec) begin
      cnt_n = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt_n = cnt - CNT_W'(1);
    end
  end

  assign full_nxt_c = (cnt_n >= CNT_W'(MAX_OUTST));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_n;
    end
  end

endmodule

// File: rtl/sdram_read_checker.sv
// SDRAM read checker: streams single-word reads over a window and compares
// every returned word against the shared test pattern.
module sdram_read_checker #(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = sdram_test_pkg::DATA_W,
  parameter int unsigned MAX_OUTST = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_stb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] size_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] err_cnt_o,
  output logic [31:0] first_err_idx_o,
  sdram_read_checker_if.master sdram
);

  import sdram_test_pkg::*;

  localparam int unsigned CNT_W = 32;

  state_e            state, state_n;
  logic [CNT_W-1:0]  base_q, base_n;
  logic [CNT_W-1:0]  size_q, size_n;
  logic [CNT_W-1:0]  req_cnt, req_n;
  logic [CNT_W-1:0]  rcv_cnt, rcv_n;
  logic [CNT_W-1:0]  err_cnt, err_n;
  logic [CNT_W-1:0]  first_q, first_n;
  logic [CNT_W-1:0]  cyc_cnt, cyc_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              busy_q, done_q, done_n, read_q, read_n;
  logic              start_c, accept_c, beat_c, mismatch_c, full_nxt_c;

  assign accept_c   = read_q && !sdram.waitrequest;
  assign beat_c     = sdram.readdatavalid && (state != ST_IDLE);
  assign mismatch_c = beat_c &&
                      (sdram.readdata != DATA_W'(pattern_word(IDX_W'(rcv_cnt))));

  sdram_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst_cnt (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (start_c),
    .inc        (accept_c),
    .dec        (beat_c),
    .full_nxt_c (full_nxt_c)
  );

  // Next-state and next-value logic; read/address are registered from the
  // next values so they stay stable while the slave stalls.
  always_comb begin
    state_n = state;
    base_n  = base_q;
    size_n  = size_q;
    req_n   = req_cnt;
    rcv_n   = rcv_cnt;
    err_n   = err_cnt;
    first_n = first_q;
    cyc_n   = cyc_cnt;
    done_n  = 1'b0;
    start_c = 1'b0;

    case (state)
      ST_IDLE: begin
        if (run_stb_i) begin
          base_n  = addr_i;
          size_n  = size_i;
          req_n   = '0;
          rcv_n   = '0;
          err_n   = '0;
          first_n = '0;
          cyc_n   = '0;
          if (size_i == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = ST_ISSUE;
            start_c = 1'b1;
          end
        end
      end
      ST_ISSUE, ST_DRAIN: begin
        cyc_n = cyc_cnt + CNT_W'(1);
        if (accept_c) begin
          req_n = req_cnt + CNT_W'(1);
          if (req_n == size_q) state_n = ST_DRAIN;
        end
        if (beat_c) begin
          rcv_n = rcv_cnt + CNT_W'(1);
          if (mismatch_c) begin
            if (err_cnt != '1) err_n = err_cnt + CNT_W'(1);
            if (err_cnt == '0) first_n = rcv_cnt;
          end
          if (rcv_cnt == size_q - CNT_W'(1)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    read_n = (state_n == ST_ISSUE) && (req_n < size_n) && !full_nxt_c;
    addr_n = ADDR_W'(base_n + req_n);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      base_q  <= '0;
      size_q  <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
      err_cnt <= '0;
      first_q <= '0;
      cyc_cnt <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state   <= state_n;
      base_q  <= base_n;
      size_q  <= size_n;
      req_cnt <= req_n;
      rcv_cnt <= rcv_n;
      err_cnt <= err_n;
      first_q <= first_n;
      cyc_cnt <= cyc_n;
      addr_q  <= addr_n;
      busy_q  <= (state_n != ST_IDLE);
      done_q  <= done_n;
      read_q  <= read_n;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign cycle_cnt_o      = cyc_cnt;
  assign err_cnt_o        = err_cnt;
  assign first_err_idx_o  = first_q;
  assign sdram.address    = addr_q;
  assign sdram.read       = read_q;
  assign sdram.burstcount = 8'd1;

endmodule

// File: doc/sdram_read_checker.md
SDRAM_READ_CHECKER -- requirements
Module: sdram_read_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, SDRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 128, SDRAM data width (fixed at 128 for the pattern).
REQ-003 SHALL have parameter MAX_OUTST, default 16, maximum number of reads in flight (range 1..64).
REQ-004 SHALL have ports, one per line:
- clk_i  in  1  single clock; all logic on its rising edge
- rst_i  in  1  reset; synchronous, active-high
- run_stb_i  in  1  one-cycle start strobe
- addr_i  in  32  base word address; sampled at start
- size_i  in  32  word count; sampled at start
- busy_o  out  1  test in progress
- done_o  out  1  one-cycle completion pulse (IRQ source)
- cycle_cnt_o  out  32  cycles spent busy in the last or current run
- err_cnt_o  out  32  mismatching words
- first_err_idx_o  out  32  word index of the first mismatch
- sdram_address_o  out  ADDR_W  Avalon-MM read address
- sdram_burstcount_o  out  8  constant 1
- sdram_read_o  out  1  read request
- sdram_waitrequest_i  in  1  slave stall
- sdram_readdata_i  in  DATA_W  read data
- sdram_readdatavalid_i  in  1  read data valid

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-006 In IDLE, run_stb_i SHALL latch addr_i and size_i, clear req_cnt, rcv_cnt, err_cnt, cycle_cnt and first_err_idx, and go to ISSUE; if size_i==0, SHALL instead pulse done_o on the next cycle and stay in IDLE.
REQ-007 run_stb_i SHALL be ignored while busy_o=1.
REQ-008 busy_o SHALL be 1 in ISSUE and DRAIN and 0 in IDLE.
REQ-009 In ISSUE, sdram_read_o SHALL be 1 whenever req_cnt<size and outst<MAX_OUTST, and 0 otherwise.
REQ-010 A read SHALL be accepted when sdram_read_o && !sdram_waitrequest_i; on acceptance, req_cnt SHALL increment.
REQ-011 While stalled (waitrequest=1), address and read SHALL hold stable.
REQ-012 sdram_address_o SHALL equal (base + req_cnt) modulo 2^ADDR_W; wrap-around is silent.
REQ-013 outst SHALL increment on accept and decrement on readdatavalid; a simultaneous accept and valid SHALL leave outst unchanged.
REQ-014 When the last read is accepted (req_cnt reaches size), the FSM SHALL go to DRAIN and deassert sdram_read_o in the following cycle.
REQ-015 On each readdatavalid in ISSUE or DRAIN, readdata SHALL be compared with the expected pattern {~rcv_cnt[63:0], rcv_cnt[63:0]}, where rcv_cnt is zero-extended to 64 bits; rcv_cnt SHALL then increment.
REQ-016 On a mismatch, err_cnt SHALL increment, saturating at 0xFFFFFFFF; first_err_idx SHALL capture rcv_cnt on the first mismatch only.
REQ-017 The cycle when the final valid word arrives (rcv_cnt==size-1) SHALL be the completion cycle.
- done_o SHALL pulse 1 in the next cycle.
- The FSM SHALL return to IDLE in that same next cycle.
- All status registers SHALL be final when done_o=1.
REQ-018 cycle_cnt SHALL increment every cycle while busy_o=1 and hold in IDLE.
REQ-019 readdatavalid in IDLE SHALL be ignored (no count or compare changes).
REQ-020 The compare path SHALL have at most one register stage; the completion pulse latency (REQ-017) SHALL include that stage.

Reset
REQ-021 rst_i=1 SHALL force FSM=IDLE and clear sdram_read_o, busy_o, done_o, outst, req_cnt, rcv_cnt, cycle_cnt, err_cnt and first_err_idx to 0.
REQ-022 Reset mid-run SHALL abort immediately with no done_o pulse; late readdatavalid beats SHALL be ignored per REQ-019.
REQ-023 sdram_burstcount_o SHALL be constant 1, including during reset.

Structure
REQ-024 Shared package sdram_test_pkg SHALL hold:
- the FSM state enum
- DATA_W
- the pattern function, shared with the SDRAM writer so write and read patterns cannot diverge.
REQ-025 The block SHALL contain one sub-module, sdram_outst_cnt: an up/down in-flight counter with a full flag at MAX_OUTST.

Verification
REQ-026 Zero-wait slave with 1-cycle latency, base=0x100, size=8:
- 8 reads at addresses 0x100..0x107
- err_cnt=0
- done_o pulses once, then busy_o=0.
REQ-027 Random waitrequest at 50%, size=64: address and read stable while stalled; exactly 64 accepts; err_cnt=0.
REQ-028 Slave corrupts word 5 (bit 0) and word 9, size=16: err_cnt=2, first_err_idx=5.
REQ-029 MAX_OUTST=4, slave latency 20 cycles, size=32: outst never exceeds 4; done_o pulses after all 32 valids.
REQ-030 size=0 -> done_o pulses 1 cycle after run_stb_i, no reads, cycle_cnt=0; base=0xFFFFFFE, size=4 (ADDR_W=28) -> addresses 0xFFFFFFE, 0xFFFFFFF, 0x0, 0x1.
REQ-031 rst_i asserted mid-DRAIN -> no done_o pulse; all outputs 0 next cycle; stray valids ignored; a new run then completes normally.
